// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   The WIDTH-bit add is split into STAGES equal slices. Each slice uses
//   BLOCK-bit CLA groups with group generate/propagate lookahead. Each slice
//   is registered before the next one starts.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake (a, b, cin, sub)
//     out_valid / out_ready result handshake (s, cout, ovf)
//     sub=1 computes a + ~b + 1 (cin ignored); cout=1 then means no borrow.
//     ovf is the two's-complement overflow of the effective addition.
//
//   Sub-modules (same file):
//     cla_slice  combinational SW-bit CLA built from BLOCK-bit groups
//     cla_stage  one pipeline stage: slice + operand/result/carry registers
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla_slice
//   Combinational SW-bit carry-lookahead adder.
//   Ports: a, b (SW bits), ci -> s (SW bits), co.
//   Bit g/p feed per-group G/P. Group carries are lookahead
//   sum-of-products over G/P. Bit carries inside a group are lookahead
//   over the bit g/p, starting from that group's carry-in.
// ---------------------------------------------------------------------------
module cla_slice #(
    parameter int SW    = 8,
    parameter int BLOCK = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);
    localparam int NG = SW / BLOCK;

    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic acc, run;
        gg  = '0;
        gp  = '0;
        gc  = '0;
        c   = '0;
        acc = 1'b0;
        run = 1'b1;

        // Group G/P. Walking down from the MSB, run is the AND of the
        // propagates above bit i.
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int i = BLOCK - 1; i >= 0; i--) begin
                acc = acc | (run & g[j*BLOCK+i]);
                run = run & p[j*BLOCK+i];
            end
            gg[j] = acc;
            gp[j] = run;
        end

        // Group carries: C[j+1] = OR_m G[m]&P[m+1..j]  |  P[0..j]&ci
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int m = j; m >= 0; m--) begin
                acc = acc | (run & gg[m]);
                run = run & gp[m];
            end
            gc[j+1] = acc | (run & ci);
        end

        // Bit carries inside each group, based on that group's carry-in.
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                acc = 1'b0;
                run = 1'b1;
                for (int k = i - 1; k >= 0; k--) begin
                    acc = acc | (run & g[j*BLOCK+k]);
                    run = run & p[j*BLOCK+k];
                end
                c[j*BLOCK+i] = acc | (run & gc[j]);
            end
        end
    end

    assign s  = p ^ c;
    assign co = gc[NG];
endmodule

// ---------------------------------------------------------------------------
// cla_stage
//   One pipeline stage. It resolves result bits [LO +: SW] from the
//   incoming carry. It then registers the full operands (later slices still
//   need the upper bits), the partial sum, the slice carry-out and an
//   overflow flag. The overflow flag is only meaningful once the MSB is
//   resolved.
//   Ports: ld (stage may load), vin/vout valid in/out, a/b/c/s in and out,
//          ov_o registered overflow.
// ---------------------------------------------------------------------------
module cla_stage #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int SW    = 8,
    parameter int LO    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             vin,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             vout,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             c_o,
    output logic [WIDTH-1:0] s_o,
    output logic             ov_o
);
    logic [SW-1:0]    ss;
    logic             co;
    logic [WIDTH-1:0] s_nxt;
    logic             ov_nxt;
    logic             unused_slice;

    cla_slice #(.SW(SW), .BLOCK(BLOCK)) u_slice (
        .a  (a_i[LO+:SW]),
        .b  (b_i[LO+:SW]),
        .ci (c_i),
        .s  (ss),
        .co (co)
    );

    // Incoming result bits in this slice are still zero; the new ones replace them.
    assign unused_slice = ^s_i[LO+:SW];

    always_comb begin
        s_nxt         = s_i;
        s_nxt[LO+:SW] = ss;
    end

    assign ov_nxt = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (s_nxt[WIDTH-1] != a_i[WIDTH-1]);

    // Data loads only with a real transaction. A held result stays stable,
    // and s/cout/ovf always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vout <= 1'b0;
            a_o  <= '0;
            b_o  <= '0;
            c_o  <= 1'b0;
            s_o  <= '0;
            ov_o <= 1'b0;
        end else begin
            if (ld) vout <= vin;
            if (ld && vin) begin
                a_o  <= a_i;
                b_o  <= b_i;
                c_o  <= co;
                s_o  <= s_nxt;
                ov_o <= ov_nxt;
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// cla_pipe_adder (top)
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    // Index 0 is the operand input; index k+1 is the output of stage k.
    logic [STAGES:0][WIDTH-1:0] pa, pb, ps;
    logic [STAGES:0]            pc, vld_pipe, ld;
    logic [STAGES:1]            pov;
    logic                       unused_top;

    assign pa[0]       = a;
    assign pb[0]       = sub ? ~b : b;
    assign pc[0]       = sub | cin;
    assign ps[0]       = '0;
    assign vld_pipe[0] = in_valid;

    // ld[k]: stage k may load this cycle. ld[STAGES] is the downstream accept.
    // A stage loads when it is empty or its content moves on. Bubbles
    // therefore collapse, and a full pipeline still advances when out_ready=1.
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            ld[k] = ~vld_pipe[k+1] | ld[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_stage #(.WIDTH(WIDTH), .BLOCK(BLOCK), .SW(SW), .LO(k*SW)) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .ld   (ld[k]),
            .vin  (vld_pipe[k]),
            .a_i  (pa[k]),
            .b_i  (pb[k]),
            .c_i  (pc[k]),
            .s_i  (ps[k]),
            .vout (vld_pipe[k+1]),
            .a_o  (pa[k+1]),
            .b_o  (pb[k+1]),
            .c_o  (pc[k+1]),
            .s_o  (ps[k+1]),
            .ov_o (pov[k+1])
        );
    end

    // Only the last stage's overflow is a finished result. The final operand copies are dead.
    assign unused_top = ^{pa[STAGES], pb[STAGES], pov};

    assign in_ready  = ld[0];
    assign out_valid = vld_pipe[STAGES];
    assign s         = ps[STAGES];
    assign cout      = pc[STAGES];
    assign ovf       = pov[STAGES];
endmodule
